// File: rtl/mem_pkg.sv
// Shared encodings for the load/store stage: funct3 codes, FSM states, byte-enable bases.
package mem_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational datapath: access legality, store lane steering, load extraction/extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  chk_op_i,
    input  logic [1:0]  chk_off_i,
    input  logic        chk_we_i,
    output logic        fault_o,
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] rd_shift;

    // Unsigned variants (op[2]) only exist for loads, so a store with op[2] is illegal.
    always_comb begin
        fault_o = 1'b0;
        case (chk_op_i)
            MEM_LB, MEM_LBU: fault_o = chk_we_i && chk_op_i[2];
            MEM_LH, MEM_LHU: fault_o = chk_off_i[0] || (chk_we_i && chk_op_i[2]);
            MEM_LW:          fault_o = |chk_off_i;
            default:         fault_o = 1'b1;
        endcase
    end

    always_comb begin
        wstrb_o = WSTRB_W;
        wdata_o = wdata_i;
        case (op_i[1:0])
            2'b00: begin
                wstrb_o = WSTRB_B << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = off_i[1] ? (WSTRB_H << 2) : WSTRB_H;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = rdata_i >> {off_i, 3'b000};

    always_comb begin
        ldata_o = rdata_i;
        case (op_i)
            MEM_LB:  ldata_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
            MEM_LBU: ldata_o = {24'd0, rd_shift[7:0]};
            MEM_LH:  ldata_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
            MEM_LHU: ldata_o = {16'd0, rd_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Multi-cycle load/store stage: valid/ready request, response channel, timeout abort.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q, load_data_q;
    logic [2:0]       op_q;
    logic             we_q, misalign_q, bus_err_q;
    logic             access, fault, expired;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata, ld_data;

    assign access  = start && (mem_rd || mem_wr);
    assign cnt_d   = cnt_q + 1'b1;
    assign expired = (cnt_d == TMO);

    mem_align u_align (
        .chk_op_i  (mem_op),
        .chk_off_i (addr[1:0]),
        .chk_we_i  (mem_wr),
        .fault_o   (fault),
        .op_i      (op_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus_rdata),
        .wstrb_o   (st_wstrb),
        .wdata_o   (st_wdata),
        .ldata_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (access) begin
                    if (fault) begin
                        misalign_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        op_q    <= mem_op;
                        we_q    <= mem_wr;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
                    end
                end
                // Timeout beats a same-cycle accept; the request is abandoned.
                S_REQ: begin
                    cnt_q <= cnt_d;
                    if (expired) begin
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                        state_q     <= S_DONE;
                    end else if (bus_req_ready) begin
                        state_q <= S_RSP;
                    end
                end
                // A response arriving on the timeout cycle still completes normally.
                S_RSP: begin
                    cnt_q <= cnt_d;
                    if (bus_rsp_valid) begin
                        load_data_q <= we_q ? 32'd0 : ld_data;
                        state_q     <= S_DONE;
                    end else if (expired) begin
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    misalign_q  <= 1'b0;
                    bus_err_q   <= 1'b0;
                    load_data_q <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall         = (state_q == S_REQ) || (state_q == S_RSP) ||
                           ((state_q == S_IDLE) && access && !fault);
    assign done          = (state_q == S_DONE);
    assign load_data     = load_data_q;
    assign misalign      = misalign_q;
    assign bus_err       = bus_err_q;
    assign bus_req_valid = (state_q == S_REQ);
    assign bus_we        = bus_req_valid && we_q;
    assign bus_addr      = bus_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_wdata     = bus_we ? st_wdata : 32'd0;
    assign bus_wstrb     = bus_we ? st_wstrb : 4'd0;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Multi-cycle load/store stage directly downstream of execute. It takes the ALU Result (address), rs2 (store data) and the memory control fields. It drives a valid/ready request bus plus a response channel, and returns aligned, sign/zero-extended load data. The core stalls while the access is in flight. Byte-lane steering, alignment checks and a response timeout are handled here.

Parameters:
TIMEOUT, 255, cycles spent in REQ+RSP before the access is aborted with bus_err (minimum 2).
CNT_W, 8, width of the timeout counter; it must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  current instruction is at the memory stage; inputs are valid this cycle.
mem_rd  in  1  load.
mem_wr  in  1  store; has priority if both mem_rd and mem_wr are set.
mem_op  in  3  RV32 funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
addr  in  32  byte address (execute Result).
wdata  in  32  store data (rs2).
stall  out  1  core must hold pc/regs.
done  out  1  one-cycle completion pulse.
load_data  out  32  extended load result; valid while done=1.
misalign  out  1  access fault (misaligned address or illegal mem_op); valid with done.
bus_err  out  1  timeout fault; valid with done.
bus_req_valid  out  1  request valid.
bus_req_ready  in  1  request accepted.
bus_we  out  1  write request.
bus_addr  out  32  word-aligned address (addr[31:2], 2'b00).
bus_wdata  out  32  lane-replicated store data.
bus_wstrb  out  4  byte enables; 0000 on reads.
bus_rsp_valid  in  1  read data or write acknowledge.
bus_rdata  in  32  read data word.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, timeout counter=0, all outputs 0 (load_data included). rst overrides every other input.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE: when start && (mem_rd||mem_wr), check the access.
  - Halfword with addr[0]=1, word with addr[1:0]!=0, or illegal mem_op (011, 110, 111, or 1xx on a store): go to DONE with misalign=1. No bus request is issued.
  - Otherwise latch addr, wdata, mem_op and we, then go to REQ.
  - start with neither mem_rd nor mem_wr: stay IDLE, no stall.
- REQ:
  - bus_req_valid=1; bus_addr, bus_we, bus_wdata and bus_wstrb come from latched values and stay stable until the handshake.
  - On bus_req_valid && bus_req_ready, go to RSP. bus_req_valid drops in the cycle after acceptance.
- RSP:
  - On bus_rsp_valid, go to DONE. On reads, capture the extracted bus_rdata into load_data. Writes use rsp_valid as an ack only.
  - bus_rsp_valid is ignored in every state other than RSP.
- Timeout:
  - The counter clears on IDLE->REQ and increments every REQ/RSP cycle.
  - When it reaches TIMEOUT, go to DONE with bus_err=1 and load_data=0.
  - If bus_rsp_valid arrives in the same cycle as the timeout, the response wins.
- DONE: done=1 for exactly one cycle, then IDLE. misalign, bus_err and load_data are held in DONE and cleared on exit.
- stall: 1 in REQ and RSP, and combinationally 1 in IDLE when start && (mem_rd||mem_wr) && the access is legal. 0 in DONE and in the misaligned IDLE cycle.
- Minimum legal-access latency (ready and rsp each take one cycle): done is asserted 3 cycles after start.
- Store lanes:
  - sb: wstrb = 0001 << addr[1:0]; wdata = the byte replicated x4.
  - sh: wstrb = 0011 or 1100 (selected by addr[1]); wdata = the halfword replicated x2.
  - sw: wstrb = 1111.
- Load extract: select the byte or halfword using latched addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- Reset mid-operation: return to IDLE immediately. A late bus_rsp_valid is ignored, and no done pulse is produced.

Decomposition:
- Package mem_pkg: mem_op encodings (MEM_LB .. MEM_LHU), FSM state enum, and a wstrb constant per size.
- Sub-module mem_align: purely combinational. It handles the alignment check, store lane steering with wstrb, and load extraction/extension. The FSM and counter stay in mem_stage.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, ready on the first REQ cycle, rsp one cycle later -> bus_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, done 3 cycles after start, stall=1 throughout, then stall=0.
- lb addr 0x103, rdata 0x80123456 -> load_data 0xFFFFFF80. Same access as lbu -> 0x00000080. lh addr 0x102 -> 0xFFFF8012.
- sh addr 0x102, wdata 0x0000ABCD -> wstrb 1100, bus_wdata 0xABCDABCD, bus_addr 0x100.
- lw addr 0x102 -> misalign=1, done on the next cycle, bus_req_valid never asserted. The illegal mem_op 011 load behaves the same.
- Hold ready low for 3 cycles -> bus_addr/bus_we/bus_wdata stable every cycle. With TIMEOUT=4 and no response -> bus_err=1, load_data=0, done after 4 REQ/RSP cycles.
- Assert rst while in RSP, then drive rsp_valid the next cycle -> state IDLE, all outputs 0, no done pulse.
